// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-memory fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam int FETCH_DW       = 20;
    localparam int FETCH_AW       = 8;
    localparam int FETCH_MEM_SIZE = 256;
    localparam int FETCH_RESET_PC = 0;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the RUN state: halt, branch redirect, stall hold,
// end-of-memory detection and increment, in that priority order.
module fetch_next_pc #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256
) (
    input  logic [ADDRESS_WIDTH-1:0] i_pc,
    input  logic                     i_halt_req,
    input  logic                     i_branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_branch_target,
    input  logic                     i_stall,
    output logic [ADDRESS_WIDTH-1:0] o_next_pc,
    output logic                     o_halt,
    output logic                     o_err
);

    // Range checks are done one bit wider so MEM_SIZE == 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] LP_MEM_SIZE = (ADDRESS_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDRESS_WIDTH:0] LP_LAST     = (ADDRESS_WIDTH+1)'(MEM_SIZE - 1);

    always_comb begin
        o_next_pc = i_pc;
        o_halt    = 1'b0;
        o_err     = 1'b0;
        if (i_halt_req) begin
            o_halt = 1'b1;
        end else if (i_branch_taken) begin
            if ({1'b0, i_branch_target} < LP_MEM_SIZE) begin
                o_next_pc = i_branch_target;
            end else begin
                o_err  = 1'b1;
                o_halt = 1'b1;
            end
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end else if ({1'b0, i_pc} == LP_LAST) begin
            o_err  = 1'b1;
            o_halt = 1'b1;
        end else begin
            o_next_pc = i_pc + ADDRESS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Owns the instruction-memory port: streams program words in (LOAD) and sequences the PC (RUN).
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module imem_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = FETCH_DW,
    parameter int ADDRESS_WIDTH = FETCH_AW,
    parameter int MEM_SIZE      = FETCH_MEM_SIZE,
    parameter int RESET_PC      = FETCH_RESET_PC
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_run_start,
    input  logic                     i_ld_start,
    input  logic                     i_halt_req,
    input  logic                     i_stall,
    input  logic                     i_branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_branch_target,
    input  logic                     i_ld_valid,
    input  logic                     i_ld_last,
    input  logic [DATA_WIDTH-1:0]    i_ld_data,
    output logic                     o_ld_ready,
    output logic [ADDRESS_WIDTH-1:0] o_imem_addr,
    output logic                     o_imem_we,
    output logic [DATA_WIDTH-1:0]    o_imem_wdata,
    output logic                     o_fetch_valid,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    output logic                     o_halted,
    output logic                     o_fetch_err,
    output logic [ADDRESS_WIDTH:0]   o_load_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              o_perf_fetch_cnt,
    output logic [31:0]              o_perf_stall_cnt
`endif
);

    localparam logic [ADDRESS_WIDTH:0]   LP_LAST     = (ADDRESS_WIDTH+1)'(MEM_SIZE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LP_RESET_PC = ADDRESS_WIDTH'(RESET_PC);

    fetch_state_t               r_state;
    fetch_state_t               w_state_next;
    logic [ADDRESS_WIDTH-1:0]   r_pc;
    logic [ADDRESS_WIDTH-1:0]   r_load_ptr;
    logic [ADDRESS_WIDTH:0]     r_load_count;
    logic                       r_fetch_err;
    logic [ADDRESS_WIDTH-1:0]   w_next_pc;
    logic                       w_go_halt;
    logic                       w_set_err;
    logic                       w_accept;
    logic                       w_load_done;

    fetch_next_pc #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .MEM_SIZE      (MEM_SIZE)
    ) u_next_pc (
        .i_pc            (r_pc),
        .i_halt_req      (i_halt_req),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_stall         (i_stall),
        .o_next_pc       (w_next_pc),
        .o_halt          (w_go_halt),
        .o_err           (w_set_err)
    );

    assign w_accept    = (r_state == LOAD) && i_ld_valid;
    assign w_load_done = w_accept && (i_ld_last || ({1'b0, r_load_ptr} == LP_LAST));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_ld_start)       w_state_next = LOAD;
                else if (i_run_start) w_state_next = RUN;
            end
            LOAD: if (w_load_done) w_state_next = IDLE;
            RUN:  if (w_go_halt)   w_state_next = HALT;
            HALT: begin
                if (i_ld_start)       w_state_next = LOAD;
                else if (i_run_start) w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ld_ready    = 1'b0;
        o_imem_we     = 1'b0;
        o_imem_addr   = '0;
        o_fetch_valid = 1'b0;
        case (r_state)
            LOAD: begin
                o_ld_ready  = 1'b1;
                o_imem_we   = i_ld_valid;
                o_imem_addr = r_load_ptr;
            end
            RUN: begin
                o_imem_addr   = r_pc;
                o_fetch_valid = ~i_stall;
            end
            default: ;
        endcase
    end

    assign o_imem_wdata = i_ld_data;
    assign o_pc         = r_pc;
    assign o_halted     = (r_state == HALT);
    assign o_fetch_err  = r_fetch_err;
    assign o_load_count = r_load_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_pc         <= LP_RESET_PC;
            r_load_ptr   <= '0;
            r_load_count <= '0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE, HALT: begin
                    // HALT resumes at the held PC; only a start from IDLE rewinds it.
                    if (i_ld_start) begin
                        r_load_ptr <= '0;
                    end else if (i_run_start) begin
                        r_fetch_err <= 1'b0;
                        if (r_state == IDLE) r_pc <= LP_RESET_PC;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_load_ptr <= r_load_ptr + ADDRESS_WIDTH'(1);
                        if (w_load_done) r_load_count <= {1'b0, r_load_ptr} + (ADDRESS_WIDTH+1)'(1);
                    end
                end
                RUN: begin
                    r_pc <= w_next_pc;
                    if (w_set_err) r_fetch_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;
    logic        w_run_from_idle;

    assign w_run_from_idle = (r_state == IDLE) && !i_ld_start && i_run_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else if (w_run_from_idle) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else if (r_state == RUN) begin
            if (!i_stall && (r_perf_fetch_cnt != '1)) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            if (i_stall && (r_perf_stall_cnt != '1))  r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch_cnt;
    assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench for imem_fetch_sequencer (MEM_SIZE=200) against a cycle-level behavioural model.
module tb_imem_fetch_sequencer;

    localparam int DW = 20;
    localparam int AW = 8;
    localparam int MS = 200;

    localparam int MD_IDLE = 0;
    localparam int MD_LOAD = 1;
    localparam int MD_RUN  = 2;
    localparam int MD_HALT = 3;

    logic          clk = 1'b0;
    logic          rstN;
    logic          runStart, ldStart, haltReq, stall, branchTaken;
    logic [AW-1:0] branchTarget;
    logic          ldValid, ldLast;
    logic [DW-1:0] ldData;
    logic          ldReady, imemWe, fetchValid, halted, fetchErr;
    logic [AW-1:0] imemAddr, pc;
    logic [DW-1:0] imemWdata;
    logic [AW:0]   loadCount;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perfFetch, perfStall;
`endif

    int errors = 0;
    int checks = 0;

    int          mMode, mPc, mPtr, mCount;
    bit          mErr;
    int unsigned mFetch, mStall;

    always #5 clk = ~clk;

    imem_fetch_sequencer #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MEM_SIZE      (MS),
        .RESET_PC      (0)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_run_start     (runStart),
        .i_ld_start      (ldStart),
        .i_halt_req      (haltReq),
        .i_stall         (stall),
        .i_branch_taken  (branchTaken),
        .i_branch_target (branchTarget),
        .i_ld_valid      (ldValid),
        .i_ld_last       (ldLast),
        .i_ld_data       (ldData),
        .o_ld_ready      (ldReady),
        .o_imem_addr     (imemAddr),
        .o_imem_we       (imemWe),
        .o_imem_wdata    (imemWdata),
        .o_fetch_valid   (fetchValid),
        .o_pc            (pc),
        .o_halted        (halted),
        .o_fetch_err     (fetchErr),
        .o_load_count    (loadCount)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetch_cnt (perfFetch),
        .o_perf_stall_cnt (perfStall)
`endif
    );

    function automatic int unsigned satInc(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mMode = MD_IDLE; mPc = 0; mPtr = 0; mCount = 0; mErr = 0; mFetch = 0; mStall = 0;
    endtask

    // One rising edge of the reference behaviour, using the inputs currently driven.
    task automatic modelClock();
        case (mMode)
            MD_IDLE: begin
                if (ldStart) begin
                    mMode = MD_LOAD; mPtr = 0;
                end else if (runStart) begin
                    mMode = MD_RUN; mPc = 0; mErr = 0; mFetch = 0; mStall = 0;
                end
            end
            MD_LOAD: begin
                if (ldValid) begin
                    if (ldLast || mPtr == MS - 1) begin
                        mCount = mPtr + 1;
                        mMode  = MD_IDLE;
                    end
                    mPtr++;
                end
            end
            MD_RUN: begin
                if (stall) mStall = satInc(mStall);
                else       mFetch = satInc(mFetch);
                if (haltReq) begin
                    mMode = MD_HALT;
                end else if (branchTaken) begin
                    if (int'(branchTarget) < MS) mPc = int'(branchTarget);
                    else begin mErr = 1; mMode = MD_HALT; end
                end else if (!stall) begin
                    if (mPc == MS - 1) begin mErr = 1; mMode = MD_HALT; end
                    else mPc++;
                end
            end
            default: begin
                if (ldStart) begin
                    mMode = MD_LOAD; mPtr = 0;
                end else if (runStart) begin
                    mMode = MD_RUN; mErr = 0;
                end
            end
        endcase
    endtask

    task automatic checkOutput();
        chk("ld_ready",    {31'd0, ldReady},    {31'd0, mMode == MD_LOAD});
        chk("imem_we",     {31'd0, imemWe},     {31'd0, (mMode == MD_LOAD) && ldValid});
        chk("imem_addr",   32'(imemAddr),       (mMode == MD_LOAD) ? mPtr : ((mMode == MD_RUN) ? mPc : 0));
        chk("imem_wdata",  32'(imemWdata),      32'(ldData));
        chk("fetch_valid", {31'd0, fetchValid}, {31'd0, (mMode == MD_RUN) && !stall});
        chk("pc",          32'(pc),             mPc);
        chk("halted",      {31'd0, halted},     {31'd0, mMode == MD_HALT});
        chk("fetch_err",   {31'd0, fetchErr},   {31'd0, mErr});
        chk("load_count",  32'(loadCount),      mCount);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch",  perfFetch,           mFetch);
        chk("perf_stall",  perfStall,           mStall);
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input bit rs, input bit ls, input bit hr, input bit st,
                                 input bit bt, input int tgt, input bit lv, input bit ll,
                                 input int data);
        runStart = rs; ldStart = ls; haltReq = hr; stall = st; branchTaken = bt;
        branchTarget = tgt[AW-1:0]; ldValid = lv; ldLast = ll; ldData = data[DW-1:0];
        #1;
        checkOutput();
        @(posedge clk);
        modelClock();
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        runStart = 0; ldStart = 0; haltReq = 0; stall = 0; branchTaken = 0;
        branchTarget = '0; ldValid = 0; ldLast = 0; ldData = '0;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput();
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b1;
        runStart = 0; ldStart = 0; haltReq = 0; stall = 0; branchTaken = 0;
        branchTarget = '0; ldValid = 0; ldLast = 0; ldData = '0;
        modelReset();
        @(negedge clk);
        doReset();
        chk("reset_addr", 32'(imemAddr), 0);

        // Program load of four words, last flagged on the fourth.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, (i == 4), i);
        chk("load_count_4", 32'(loadCount), 4);
        chk("ld_ready_after_load", {31'd0, ldReady}, 0);

        // Run, stall at pc=5, branch to 0x40 while stalled.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) idleCycle();
        chk("pc_before_stall", 32'(pc), 5);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("pc_held_by_stall", 32'(pc), 5);
        applyStimulus(0, 0, 0, 1, 1, 8'h40, 0, 0, 0);
        chk("pc_branch_in_stall", 32'(pc), 8'h40);

        // Run off the end of memory: no wrap, sticky error, HALT.
        for (int i = 0; i < 140; i++) idleCycle();
        chk("overrun_err", {31'd0, fetchErr}, 1);
        chk("overrun_pc", 32'(pc), MS - 1);
        chk("overrun_halted", {31'd0, halted}, 1);

        // Resume, then branch beyond MEM_SIZE.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("resume_err_cleared", {31'd0, fetchErr}, 0);
        applyStimulus(0, 0, 0, 0, 1, 210, 0, 0, 0);
        chk("bad_target_err", {31'd0, fetchErr}, 1);
        chk("bad_target_halted", {31'd0, halted}, 1);

        // Halt at pc=7 (ld_start ignored in RUN), then resume there.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 7, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
        idleCycle();
        chk("halt_pc7", 32'(pc), 7);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idleCycle();
        chk("resume_from_7", 32'(pc), 10);

        // Load from HALT (ld_start beats run_start), aborted by reset after two words.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 20'hABCDE);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 20'h12345);
        doReset();
        chk("abort_ld_ready", {31'd0, ldReady}, 0);
        chk("abort_load_count", 32'(loadCount), 0);

        // Full-memory load without ld_last ends at the last address.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MS + 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, $urandom);
        chk("full_load_count", 32'(loadCount), MS);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 2) doReset();
            else applyStimulus($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
                               $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
                               $urandom_range(0, 99) < 8, int'($urandom_range(0, 255)),
                               $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
                               int'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
